aes_req_arbiter: RTL

Controller sharing one `aes_core` instance between two requesters: requester 0 is the SRAM write/encrypt path and requester 1 is the SRAM read/decrypt path. It sequences key expansion (`init`) whenever a new master key is loaded, then serves block requests (`next`) with round-robin fairness. It returns each result to the granted requester with a one-cycle done pulse. A watchdog flags a stuck core. The block sits between the SRAM Wishbone wrapper's read/write FSMs and the AES core, and replaces ad-hoc busy-based muxing.

---
 rtl/aes_arb_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/aes_req_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_arb_pkg.sv
// ---------------------------------------------------------------------------
// aes_arb_pkg
// Shared types and constants for the AES request arbiter slice.
//   arb_state_t : controller states (key expansion path and block path)
//   REQ_WR      : requester index of the SRAM write / encrypt path
//   REQ_RD      : requester index of the SRAM read / decrypt path
//   BLOCK_WD    : default AES block width
//   TMO_CYC     : default watchdog limit, in cycles spent in a wait state
//   WD_W        : width of the watchdog counter
// ---------------------------------------------------------------------------
package aes_arb_pkg;

   localparam int BLOCK_WD = 128;
   localparam int TMO_CYC  = 255;
   localparam int WD_W     = 8;

   localparam int REQ_WR = 0;
   localparam int REQ_RD = 1;

   typedef enum logic [2:0] {
      S_NOKEY  = 3'd0,
      S_KINIT  = 3'd1,
      S_KGUARD = 3'd2,
      S_KWAIT  = 3'd3,
      S_IDLE   = 3'd4,
      S_NISSUE = 3'd5,
      S_NGUARD = 3'd6,
      S_NWAIT  = 3'd7
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   req  [1:0] : request lines, bit N = requester N
//   last       : index of the requester served most recently
//   gnt  [1:0] : one-hot grant, all zero when nothing is requested
// A lone request always wins; on a tie the requester that was not served
// last wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/aes_req_arbiter.sv
// ---------------------------------------------------------------------------
// aes_req_arbiter
// Shares one aes_core between the SRAM write/encrypt path (requester 0) and
// the SRAM read/decrypt path (requester 1). Runs key expansion whenever a
// new master key is loaded, then serves block requests round-robin and
// returns each result with a one-cycle done pulse to the owner.
//
// Ports
//   wb_clk_i, rst          : clock, synchronous active-high reset
//   key_load_i             : one-cycle pulse, new master key on the core
//   key_ready_o            : key expanded, block requests are accepted
//   reqN_i / reqN_encdec_i : request (held until doneN_o) and direction
//   reqN_block_i           : input block of requester N
//   doneN_o                : one-cycle pulse, result_o is valid for N
//   result_o               : last captured core result
//   grant_o                : one-hot owner of the core
//   busy_o                 : a key expansion or block operation is running
//   tmo_o                  : sticky watchdog flag, cleared only by rst
//   aes_init_o/next_o      : core strobes, one cycle wide
//   aes_encdec_o/block_o   : core data inputs, from the grant latches
//   aes_ready_i/valid_i    : core status
//   aes_result_i           : core result
// ---------------------------------------------------------------------------
module aes_req_arbiter #(
   parameter int BLOCK_WD = aes_arb_pkg::BLOCK_WD,
   parameter int TMO_CYC  = aes_arb_pkg::TMO_CYC
) (
   input  logic                wb_clk_i,
   input  logic                rst,

   input  logic                key_load_i,
   output logic                key_ready_o,

   input  logic                req0_i,
   input  logic                req0_encdec_i,
   input  logic [BLOCK_WD-1:0] req0_block_i,
   input  logic                req1_i,
   input  logic                req1_encdec_i,
   input  logic [BLOCK_WD-1:0] req1_block_i,

   output logic                done0_o,
   output logic                done1_o,
   output logic [BLOCK_WD-1:0] result_o,
   output logic [1:0]          grant_o,
   output logic                busy_o,
   output logic                tmo_o,

   output logic                aes_init_o,
   output logic                aes_next_o,
   output logic                aes_encdec_o,
   output logic [BLOCK_WD-1:0] aes_block_o,
   input  logic                aes_ready_i,
   input  logic                aes_valid_i,
   input  logic [BLOCK_WD-1:0] aes_result_i
);

   import aes_arb_pkg::*;

   // The counter starts at 0 on the first wait cycle, so firing on
   // TMO_CYC-1 puts NOKEY and tmo_o exactly TMO_CYC cycles after entry.
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TMO_CYC - 1);

   arb_state_t      state_q;
   arb_state_t      state_d;
   logic            key_pend_q;
   logic            last_q;
   logic [WD_W-1:0] wd_q;
   logic [1:0]      rr_gnt;

   logic            key_kick;
   logic            go_kinit;
   logic            grant_set;
   logic            blk_done;
   logic            wd_fire;
   logic            wait_d;

   rr_arb2 u_rr_arb2 (
      .req  ({req1_i, req0_i}),
      .last (last_q),
      .gnt  (rr_gnt)
   );

   // A key load seen this cycle counts the same as one left pending.
   assign key_kick = key_load_i | key_pend_q;

   assign wait_d = (state_d == S_KWAIT) || (state_d == S_NWAIT);

   assign aes_init_o = (state_q == S_KINIT);
   assign aes_next_o = (state_q == S_NISSUE);

   // NOKEY is the reset state and must read as not busy.
   assign busy_o = (state_q != S_IDLE) && (state_q != S_NOKEY);

   always_comb begin
      state_d   = state_q;
      go_kinit  = 1'b0;
      grant_set = 1'b0;
      blk_done  = 1'b0;
      wd_fire   = 1'b0;
      case (state_q)
         S_NOKEY: begin
            if (key_kick) begin
               state_d  = S_KINIT;
               go_kinit = 1'b1;
            end
         end
         S_KINIT:  state_d = S_KGUARD;
         // The core's ready is still stale for one cycle after init.
         S_KGUARD: state_d = S_KWAIT;
         S_KWAIT: begin
            if (aes_ready_i) begin
               state_d = S_IDLE;
            end else if (wd_q == WD_LIMIT) begin
               state_d = S_NOKEY;
               wd_fire = 1'b1;
            end
         end
         S_IDLE: begin
            if (key_kick) begin
               state_d  = S_KINIT;
               go_kinit = 1'b1;
            end else if (rr_gnt != 2'b00) begin
               state_d   = S_NISSUE;
               grant_set = 1'b1;
            end
         end
         S_NISSUE: state_d = S_NGUARD;
         // valid from the previous block is still visible for one cycle.
         S_NGUARD: state_d = S_NWAIT;
         S_NWAIT: begin
            if (aes_valid_i) begin
               state_d  = S_IDLE;
               blk_done = 1'b1;
            end else if (wd_q == WD_LIMIT) begin
               state_d = S_NOKEY;
               wd_fire = 1'b1;
            end
         end
         default: state_d = S_NOKEY;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         state_q      <= S_NOKEY;
         key_pend_q   <= 1'b0;
         last_q       <= 1'b1;
         wd_q         <= '0;
         key_ready_o  <= 1'b0;
         tmo_o        <= 1'b0;
         grant_o      <= 2'b00;
         done0_o      <= 1'b0;
         done1_o      <= 1'b0;
         result_o     <= '0;
         aes_encdec_o <= 1'b0;
         aes_block_o  <= '0;
      end else begin
         state_q <= state_d;

         // Loads that arrive while KINIT cannot start right away are
         // remembered; the flag survives a watchdog timeout.
         if (go_kinit) begin
            key_pend_q <= 1'b0;
         end else if (key_load_i) begin
            key_pend_q <= 1'b1;
         end

         // key_ready_o is not raised when another expansion is queued.
         if (key_load_i || wd_fire) begin
            key_ready_o <= 1'b0;
         end else if ((state_q == S_KWAIT) && aes_ready_i && !key_pend_q) begin
            key_ready_o <= 1'b1;
         end

         if (wait_d && (state_d != state_q)) begin
            wd_q <= '0;
         end else if (wait_d) begin
            wd_q <= wd_q + 1'b1;
         end

         if (wd_fire) begin
            tmo_o <= 1'b1;
         end

         if (grant_set) begin
            grant_o <= rr_gnt;
            if (rr_gnt[REQ_RD]) begin
               aes_encdec_o <= req1_encdec_i;
               aes_block_o  <= req1_block_i;
            end else begin
               aes_encdec_o <= req0_encdec_i;
               aes_block_o  <= req0_block_i;
            end
         end else if (blk_done || wd_fire) begin
            grant_o <= 2'b00;
         end

         done0_o <= blk_done & grant_o[REQ_WR];
         done1_o <= blk_done & grant_o[REQ_RD];

         if (blk_done) begin
            result_o <= aes_result_i;
            last_q   <= grant_o[REQ_RD];
         end
      end
   end

endmodule
